// File: rtl/spi_reg_master.sv
// spi_reg_master: host-side SPI master (mode 0, MSB first) for register access.
// Sends a command byte {write, zone, addr[5:0]}. A write frame follows it with
// the data byte. A read frame follows it with a dummy byte, then clocks in the
// response byte.
// Optional build macro SPI_REG_MASTER_WR_VERIFY_EN: every write is followed by
// an automatic read-back of the same register. The response is reported only
// after that read-back, and verify_err flags any difference.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// S_IDLE     | waiting for a request, req_ready=1
// S_CS_SETUP | cs_n low, sclk low, command MSB on mosi, CLK_DIV cycles
// S_SHIFT    | per bit: sclk low CLK_DIV cycles, then high CLK_DIV cycles
// S_CS_HOLD  | cs_n low, sclk low, CLK_DIV cycles before cs_n release
// S_GAP      | cs_n high for CLK_DIV cycles (rsp_valid in its first cycle)

module spi_reg_master #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_write,
    input  logic       req_zone,
    input  logic [5:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       busy,
    output logic       sclk,
    output logic       cs_n,
    output logic       mosi,
    input  logic       miso
`ifdef SPI_REG_MASTER_WR_VERIFY_EN
    ,
    output logic       verify_err
`endif
);

    localparam int DW = (CLK_DIV < 2) ? 1 : $clog2(CLK_DIV);
    localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CS_SETUP,
        S_SHIFT,
        S_CS_HOLD,
        S_GAP
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [DW-1:0]   div_cnt;
    logic            phase_hi;
    logic [2:0]      bit_cnt;
    logic [1:0]      byte_cnt;
    logic [23:0]     tx_sr;
    logic [7:0]      rx_sr;
    logic            wr_q;
    logic            vfy_pending;
    logic            tc;
    logic            last_bit;
    logic            shift_end;
    logic [7:0]      cmd;

`ifdef SPI_REG_MASTER_WR_VERIFY_EN
    logic            zone_q;
    logic [5:0]      addr_q;
    logic [7:0]      wdata_q;
`else
    assign vfy_pending = 1'b0;
`endif

    assign cmd       = {req_write, req_zone, req_addr};
    assign tc        = (div_cnt == '0);
    assign last_bit  = (bit_cnt == 3'd7) && (byte_cnt == (wr_q ? 2'd1 : 2'd2));
    assign shift_end = (state_q == S_SHIFT) && tc && phase_hi && last_bit;

    assign req_ready = (state_q == S_IDLE);
    assign busy      = ~req_ready;
    assign cs_n      = ~((state_q == S_CS_SETUP) || (state_q == S_SHIFT) || (state_q == S_CS_HOLD));
    assign sclk      = (state_q == S_SHIFT) && phase_hi;
    assign mosi      = ~cs_n & tx_sr[23];

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     if (req_valid) state_d = S_CS_SETUP;
            S_CS_SETUP: if (tc) state_d = S_SHIFT;
            S_SHIFT:    if (shift_end) state_d = S_CS_HOLD;
            S_CS_HOLD:  if (tc) state_d = S_GAP;
            S_GAP:      if (tc) state_d = vfy_pending ? S_CS_SETUP : S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    // Phase timer: reloads on every state change and at each half-period end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else if (state_d == S_IDLE) begin
            div_cnt <= '0;
        end else if ((state_d != state_q) || tc) begin
            div_cnt <= DIV_MAX;
        end else begin
            div_cnt <= div_cnt - DW'(1);
        end
    end

    // Frame datapath: capture, shift, bit/byte counting, response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_hi  <= 1'b0;
            bit_cnt   <= 3'd0;
            byte_cnt  <= 2'd0;
            tx_sr     <= 24'h0;
            rx_sr     <= 8'h00;
            wr_q      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 8'h00;
`ifdef SPI_REG_MASTER_WR_VERIFY_EN
            zone_q      <= 1'b0;
            addr_q      <= 6'h00;
            wdata_q     <= 8'h00;
            vfy_pending <= 1'b0;
            verify_err  <= 1'b0;
`endif
        end else begin
            rsp_valid <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        wr_q     <= req_write;
                        tx_sr    <= req_write ? {cmd, req_wdata, 8'h00} : {cmd, 16'h0000};
                        phase_hi <= 1'b0;
                        bit_cnt  <= 3'd0;
                        byte_cnt <= 2'd0;
`ifdef SPI_REG_MASTER_WR_VERIFY_EN
                        zone_q      <= req_zone;
                        addr_q      <= req_addr;
                        wdata_q     <= req_wdata;
                        vfy_pending <= 1'b0;
`endif
                    end
                end
                S_SHIFT: begin
                    if (tc) begin
                        phase_hi <= ~phase_hi;
                        if (!phase_hi) begin
                            // low phase ending: sclk rises now, sample miso
                            rx_sr <= {rx_sr[6:0], miso};
                        end else begin
                            // high phase ending: sclk falls, present next bit
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                byte_cnt <= byte_cnt + 2'd1;
                            end
                            if (!last_bit) begin
                                tx_sr <= {tx_sr[22:0], 1'b0};
                            end
                        end
                    end
                end
                S_CS_HOLD: begin
                    byte_cnt <= 2'd0;
                    if (tc) begin
`ifdef SPI_REG_MASTER_WR_VERIFY_EN
                        if (wr_q) begin
                            // write frame done: read-back follows after the gap
                            vfy_pending <= 1'b1;
                        end else begin
                            rsp_valid <= 1'b1;
                            rsp_rdata <= rx_sr;
                            if (vfy_pending) begin
                                verify_err  <= (rx_sr != wdata_q);
                                vfy_pending <= 1'b0;
                            end
                        end
`else
                        rsp_valid <= 1'b1;
                        if (!wr_q) begin
                            rsp_rdata <= rx_sr;
                        end
`endif
                    end
                end
                S_GAP: begin
`ifdef SPI_REG_MASTER_WR_VERIFY_EN
                    if (tc && vfy_pending) begin
                        tx_sr    <= {1'b0, zone_q, addr_q, 16'h0000};
                        wr_q     <= 1'b0;
                        phase_hi <= 1'b0;
                        bit_cnt  <= 3'd0;
                        byte_cnt <= 2'd0;
                    end
`endif
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/spi_reg_master.md
Name: spi_reg_master

Overview:
- Host-side SPI master that issues register-access commands to the peripheral's SPI slave and instruction decoder.
- Accepts one register request at a time (read or write, zone, 6-bit address, data) over a valid/ready handshake.
- Serialises the request as the two-/three-byte command frame and returns read data to the host.
- Sits between the host/test controller and the SPI pins.

Parameters:
- CLK_DIV, 4, clk cycles per sclk half-period (>=1); sclk period = 2*CLK_DIV clk cycles.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous, active-low; clock clk
- req_valid  in  1  request present
- req_ready  out  1  master idle and able to accept
- req_write  in  1  1=write, 0=read
- req_zone  in  1  memory zone select (1=[15:8], 0=[7:0])
- req_addr  in  6  register address
- req_wdata  in  8  write data
- rsp_valid  out  1  one-cycle pulse at transaction completion
- rsp_rdata  out  8  read data, valid with rsp_valid
- busy  out  1  transaction in progress (~req_ready)
- sclk  out  1  SPI clock, mode 0 (idle low)
- cs_n  out  1  chip select, active low
- mosi  out  1  serial data to slave, MSB first
- miso  in  1  serial data from slave, MSB first

Behaviour:
- Reset values: req_ready=1, busy=0, rsp_valid=0, rsp_rdata=0x00, sclk=0, cs_n=1, mosi=0. State=IDLE, all counters 0.
- Accept: req_valid&&req_ready in IDLE. All req_* fields are captured that cycle, and req_ready drops the next cycle. req_* are ignored while busy.
- Frame byte 0 (command) = {req_write, req_zone, req_addr}.
- Write frame: command byte, then req_wdata (16 sclk cycles).
- Read frame: command byte, then 0x00 dummy, then 0x00 while capturing miso (24 sclk cycles). The slave needs one clk after the second byte to load its response; the third byte carries it.
- States:
  - IDLE: waits for a request.
  - CS_SETUP: cs_n=0, sclk=0, mosi = command MSB; lasts CLK_DIV cycles.
  - SHIFT: per bit, sclk low for CLK_DIV cycles, then high for CLK_DIV cycles. mosi changes only on the sclk falling edge (or at CS_SETUP entry for bit 0). miso is sampled on the sclk rising edge into the shift register. A 3-bit bit counter and a 2-bit byte counter are used. After the last bit's high phase, sclk returns low and the state moves to CS_HOLD.
  - CS_HOLD: CLK_DIV cycles with cs_n=0 and sclk=0. Then cs_n=1 and rsp_valid pulses for 1 cycle. For reads, rsp_rdata = byte 2 captured from miso. For writes, rsp_rdata holds its previous value.
  - GAP: cs_n=1 for CLK_DIV cycles, then IDLE with req_ready=1.
- Write latency with CLK_DIV=4: from the accept cycle, cs_n falls at +1, rsp_valid at +1+4+128+4 = +137, and req_ready returns at +141.
- Back-to-back requests: cs_n is guaranteed high for at least CLK_DIV cycles between frames.
- CLK_DIV=1: sclk toggles every clk cycle; must still produce correct frames.
- Reset mid-frame: outputs return to reset values immediately (cs_n=1, sclk=0). A partial frame is abandoned and no rsp_valid is issued.
- The master never generates a sclk edge while cs_n=1.

Optional Feature:
- Macro: SPI_REG_MASTER_WR_VERIFY_EN.
- Defined:
  - Each write frame is automatically followed, after GAP, by a read frame to the same zone/addr.
  - rsp_valid fires only after the read-back.
  - rsp_rdata = read-back value.
  - Extra output verify_err (1 bit, reset 0) is updated with rsp_valid: 1 if read-back != written data, else 0. It holds until the next write response.
  - Read requests are unaffected (verify_err unchanged).
- Undefined: no verify_err port. A write completes after its single frame.

Test Plan:
- Write zone0 addr 0x05 data 0xA5, CLK_DIV=4 -> mosi bytes 0x85, 0xA5. cs_n low for 136 cycles. rsp_valid pulse 137 cycles after accept. Exactly 16 sclk rising edges.
- Read zone1 addr 0x12; slave model drives miso 0x3C in byte 2 -> mosi 0x52, 0x00, 0x00. rsp_rdata=0x3C with rsp_valid. 24 sclk edges.
- Hold req_valid=1 with new fields during a busy frame -> no second accept until req_ready=1. The second frame starts no earlier than CLK_DIV cycles after cs_n rises.
- Assert rst_n=0 at bit 5 of byte 1 -> cs_n=1, sclk=0 in the same cycle. No rsp_valid. A fresh write after release is correct.
- CLK_DIV=1, write addr 0x3F data 0xFF, zone1 -> mosi 0xFF, 0xFF. sclk period 2 clk cycles.
- With SPI_REG_MASTER_WR_VERIFY_EN: write 0x5A and have the slave return 0x5A -> verify_err=0. Write 0x5A and have the slave return 0x58 -> verify_err=1, rsp_rdata=0x58.
